// File: rtl/rq_rd_req_gen.sv
// DMA read-request generator: splits read descriptors into PCIe memory-read TLPs
// (MRRS and 4 KB aware), allocates tags from a bounded pool, one RQ FIFO word per TLP.
module rq_rd_req_gen #(
  parameter int TAG_NUM = 32,
  parameter int TAG_W   = 5
) (
  input  logic         user_clk,
  input  logic         user_rst,
  input  logic         desc_vld,
  output logic         desc_rdy,
  input  logic [63:0]  desc_addr,
  input  logic [31:0]  desc_len,
  output logic         desc_err,
  input  logic [2:0]   reg_mrrs_cfg,
  input  logic [15:0]  reg_req_id,
  input  logic         tag_rls,
  input  logic [7:0]   tag_rls_id,
  output logic         tag_err,
  output logic [8:0]   tag_busy_cnt,
  output logic         rq_tx_wr,
  output logic [539:0] rq_tx_wdata,
  input  logic         rq_tx_ff
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SPLIT = 2'd1,
    S_ISSUE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [63:0]          cur_addr_q, cur_addr_d;
  logic [31:0]          rem_len_q, rem_len_d;
  logic [12:0]          mrrs_q, mrrs_d;
  logic [12:0]          chunk_q, chunk_d;
  logic [TAG_NUM-1:0]   busy_q, busy_d;
  logic [8:0]           busy_cnt_q, busy_cnt_d;
  logic                 wr_q, wr_d;
  logic [539:0]         wdata_q, wdata_d;
  logic                 desc_err_q, desc_err_d;
  logic                 tag_err_q, tag_err_d;

  logic                 issue_fire_s;
  logic                 tag_free_s;
  logic [TAG_W-1:0]     alloc_tag_s;
  logic [TAG_NUM-1:0]   rls_mask_s;
  logic [TAG_NUM-1:0]   alloc_mask_s;
  logic [32:0]          room_s;
  logic [32:0]          lim_s;
  logic [32:0]          chunk_s;
  logic                 desc_bad_s;
  logic [12:0]          mrrs_dec_s;

  // Pack one single-beat RQ word; descriptor byte k lands at [511-8k -: 8].
  function automatic logic [539:0] build_word(input logic [63:0] addr,
                                              input logic [12:0] chunk,
                                              input logic [7:0]  tag,
                                              input logic [15:0] req_id);
    logic [127:0] dsc;
    logic [539:0] w;
    logic [10:0]  dw;
    dw  = chunk[12:2];
    dsc = {24'd0, tag, req_id, 1'b0, 4'b0000, dw, addr[63:2], 2'b00};
    w   = '0;
    for (int k = 0; k < 16; k++) begin
      w[511-8*k -: 8] = dsc[8*k +: 8];
    end
    w[517:512] = 6'd48;
    w[518]     = 1'b0;
    w[519]     = 1'b1;
    w[523:520] = 4'hF;
    w[527:524] = (dw > 11'd1) ? 4'hF : 4'h0;
    return w;
  endfunction

  assign desc_rdy     = (state_q == S_IDLE) && !user_rst;
  assign desc_err     = desc_err_q;
  assign tag_err      = tag_err_q;
  assign tag_busy_cnt = busy_cnt_q;
  assign rq_tx_wr     = wr_q;
  assign rq_tx_wdata  = wdata_q;

  // Chunk size candidates: remaining length, MRRS and distance to the next 4 KB line.
  always_comb begin
    desc_bad_s = (desc_len == 32'd0) || (desc_len[1:0] != 2'd0) || (desc_addr[1:0] != 2'd0);
    mrrs_dec_s = (reg_mrrs_cfg >= 3'd5) ? 13'd4096 : (13'd128 << reg_mrrs_cfg);
    room_s     = 33'd4096 - {21'd0, cur_addr_q[11:0]};
    lim_s      = ({20'd0, mrrs_q} < room_s) ? {20'd0, mrrs_q} : room_s;
    chunk_s    = ({1'b0, rem_len_q} < lim_s) ? {1'b0, rem_len_q} : lim_s;
  end

  // Lowest free tag; a tag released this cycle is still busy in busy_q.
  always_comb begin
    tag_free_s  = 1'b0;
    alloc_tag_s = '0;
    for (int i = TAG_NUM - 1; i >= 0; i--) begin
      tag_free_s  = tag_free_s | ~busy_q[i];
      alloc_tag_s = busy_q[i] ? alloc_tag_s : TAG_W'(i);
    end
  end

  // Descriptor FSM and word generation.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    rem_len_d    = rem_len_q;
    mrrs_d       = mrrs_q;
    chunk_d      = chunk_q;
    desc_err_d   = 1'b0;
    issue_fire_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (desc_vld && desc_bad_s) begin
          desc_err_d = 1'b1;
        end else if (desc_vld) begin
          cur_addr_d = desc_addr;
          rem_len_d  = desc_len;
          mrrs_d     = mrrs_dec_s;
          state_d    = S_SPLIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SPLIT: begin
        chunk_d = chunk_s[12:0];
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (!rq_tx_ff && tag_free_s) begin
          issue_fire_s = 1'b1;
          cur_addr_d   = cur_addr_q + {51'd0, chunk_q};
          rem_len_d    = rem_len_q - {19'd0, chunk_q};
          state_d      = (rem_len_q == {19'd0, chunk_q}) ? S_IDLE : S_SPLIT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    wr_d    = issue_fire_s;
    wdata_d = issue_fire_s ? build_word(cur_addr_q, chunk_q, 8'(alloc_tag_s), reg_req_id)
                           : wdata_q;
  end

  // Tag pool update: release and allocation can land on the same edge.
  always_comb begin
    for (int i = 0; i < TAG_NUM; i++) begin
      rls_mask_s[i]   = tag_rls && (tag_rls_id == 8'(i)) && busy_q[i];
      alloc_mask_s[i] = issue_fire_s && (alloc_tag_s == TAG_W'(i));
    end
    tag_err_d  = tag_rls && !(|rls_mask_s);
    busy_d     = (busy_q & ~rls_mask_s) | alloc_mask_s;
    busy_cnt_d = 9'd0;
    for (int i = 0; i < TAG_NUM; i++) begin
      busy_cnt_d = busy_cnt_d + 9'(busy_d[i]);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q    <= S_IDLE;
      cur_addr_q <= 64'd0;
      rem_len_q  <= 32'd0;
      mrrs_q     <= 13'd0;
      chunk_q    <= 13'd0;
      busy_q     <= '0;
      busy_cnt_q <= 9'd0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      desc_err_q <= 1'b0;
      tag_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_len_q  <= rem_len_d;
      mrrs_q     <= mrrs_d;
      chunk_q    <= chunk_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      desc_err_q <= desc_err_d;
      tag_err_q  <= tag_err_d;
    end
  end

endmodule

// File: tb/tb_rq_rd_req_gen.sv
// Self-checking bench for rq_rd_req_gen: vector table, hand sequences for tags,
// backpressure and reset, and random descriptors against a chunking model.
module tb_rq_rd_req_gen;
  localparam int TAG_NUM = 32;

  logic         user_clk = 1'b0;
  logic         user_rst = 1'b1;
  logic         desc_vld = 1'b0;
  logic         desc_rdy;
  logic [63:0]  desc_addr = 64'd0;
  logic [31:0]  desc_len = 32'd0;
  logic         desc_err;
  logic [2:0]   reg_mrrs_cfg = 3'd0;
  logic [15:0]  reg_req_id = 16'd0;
  logic         tag_rls = 1'b0;
  logic [7:0]   tag_rls_id = 8'd0;
  logic         tag_err;
  logic [8:0]   tag_busy_cnt;
  logic         rq_tx_wr;
  logic [539:0] rq_tx_wdata;
  logic         rq_tx_ff = 1'b0;

  int checks = 0;
  int failures = 0;
  int n_derr = 0;
  int n_terr = 0;
  logic [539:0] got_q[$];
  logic [539:0] exp_q[$];
  bit mbusy[TAG_NUM];

  typedef struct {
    logic [63:0] addr;
    logic [31:0] len;
    logic [2:0]  mrrs;
    int          exp_tlps;
    int          exp_dw0;
    int          exp_derr;
  } vec_t;
  vec_t tv[8];

  rq_rd_req_gen #(.TAG_NUM(TAG_NUM), .TAG_W(5)) dut (
    .user_clk(user_clk), .user_rst(user_rst), .desc_vld(desc_vld), .desc_rdy(desc_rdy),
    .desc_addr(desc_addr), .desc_len(desc_len), .desc_err(desc_err),
    .reg_mrrs_cfg(reg_mrrs_cfg), .reg_req_id(reg_req_id), .tag_rls(tag_rls),
    .tag_rls_id(tag_rls_id), .tag_err(tag_err), .tag_busy_cnt(tag_busy_cnt),
    .rq_tx_wr(rq_tx_wr), .rq_tx_wdata(rq_tx_wdata), .rq_tx_ff(rq_tx_ff)
  );

  always #5 user_clk = ~user_clk;

  always @(negedge user_clk) begin
    if (rq_tx_wr) got_q.push_back(rq_tx_wdata);
    if (desc_err) n_derr++;
    if (tag_err) n_terr++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [539:0] act, input logic [539:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [539:0] exp_word(input logic [63:0] a, input int bytes,
                                            input int tag, input logic [15:0] rid);
    logic [127:0] d;
    logic [539:0] w;
    int dw;
    dw = bytes / 4;
    d = '0;
    d[63:2]   = a[63:2];
    d[74:64]  = 11'(dw);
    d[95:80]  = rid;
    d[103:96] = 8'(tag);
    w = '0;
    for (int k = 0; k < 16; k++) w[511-8*k -: 8] = d[8*k +: 8];
    w[517:512] = 6'd48;
    w[519]     = 1'b1;
    w[523:520] = 4'hF;
    w[527:524] = (dw > 1) ? 4'hF : 4'h0;
    return w;
  endfunction

  function automatic logic [127:0] get_desc(input logic [539:0] w);
    logic [127:0] d;
    for (int k = 0; k < 16; k++) d[8*k +: 8] = w[511-8*k -: 8];
    return d;
  endfunction

  function automatic int model_cnt();
    int c = 0;
    for (int t = 0; t < TAG_NUM; t++) c += int'(mbusy[t]);
    return c;
  endfunction

  // Reference: carve the descriptor greedily, lowest free tag per TLP.
  task automatic model_desc(input logic [63:0] addr, input logic [31:0] len,
                            input logic [2:0] mrrs, input logic [15:0] rid);
    longint rem, room, lim, c, mb;
    logic [63:0] a;
    int tag;
    mb  = (mrrs >= 3'd5) ? 4096 : (128 << mrrs);
    rem = longint'(len);
    a   = addr;
    while (rem > 0) begin
      room = 4096 - longint'(a[11:0]);
      lim  = (mb < room) ? mb : room;
      c    = (rem < lim) ? rem : lim;
      tag  = -1;
      for (int t = TAG_NUM - 1; t >= 0; t--) if (!mbusy[t]) tag = t;
      if (tag >= 0) mbusy[tag] = 1'b1;
      exp_q.push_back(exp_word(a, int'(c), tag, rid));
      a   = a + 64'(c);
      rem = rem - c;
    end
  endtask

  task automatic send_desc(input logic [63:0] a, input logic [31:0] l, input logic [2:0] m);
    @(negedge user_clk);
    desc_addr = a; desc_len = l; reg_mrrs_cfg = m; desc_vld = 1'b1;
    for (int c = 0; c < 100 && !desc_rdy; c++) @(negedge user_clk);
    @(posedge user_clk);
    #1 desc_vld = 1'b0;
  endtask

  task automatic wait_done(input bit rnd_ff);
    int c;
    repeat (2) @(negedge user_clk);
    for (c = 0; c < 3000 && !desc_rdy; c++) begin
      @(negedge user_clk);
      #1 rq_tx_ff = rnd_ff ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
    chk("done_timeout", 64'(c < 3000), 64'd1);
    rq_tx_ff = 1'b0;
    repeat (3) @(negedge user_clk);
  endtask

  task automatic wait_writes(input int n, input int budget, input string nm);
    for (int c = 0; c < budget && got_q.size() < n; c++) begin
      @(negedge user_clk);
      #1;
    end
    chk(nm, 64'(got_q.size() >= n), 64'd1);
  endtask

  task automatic release_tag(input int id);
    @(negedge user_clk);
    tag_rls = 1'b1; tag_rls_id = 8'(id);
    @(negedge user_clk);
    tag_rls = 1'b0;
  endtask

  task automatic release_all();
    for (int t = 0; t < TAG_NUM; t++) begin
      if (mbusy[t]) begin
        release_tag(t);
        mbusy[t] = 1'b0;
      end
    end
    @(negedge user_clk);
    chk("busy_after_release", 64'(tag_busy_cnt), 64'(model_cnt()));
  endtask

  task automatic compare_writes(input string nm);
    int n;
    chk({nm, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk_w({nm, "_word"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int d0, t0, n0, n1;
    logic [63:0] ra;
    logic [31:0] rl;
    logic [2:0]  rm;
    logic [127:0] dd;

    tv[0] = '{64'h1000, 32'd256, 3'd2, 1, 64, 0};
    tv[1] = '{64'h0F80, 32'h200, 3'd2, 2, 32, 0};
    tv[2] = '{64'h0000, 32'd4, 3'd2, 1, 1, 0};
    tv[3] = '{64'h2000, 32'd4096, 3'd7, 1, 1024, 0};
    tv[4] = '{64'h0000, 32'd0, 3'd2, 0, 0, 1};
    tv[5] = '{64'h1002, 32'd8, 3'd2, 0, 0, 1};
    tv[6] = '{64'h0100, 32'd6, 3'd2, 0, 0, 1};
    tv[7] = '{64'hFFFF_FFFF_FFFF_FFC0, 32'h80, 3'd1, 2, 16, 0};

    // Reset values
    repeat (3) @(posedge user_clk);
    @(negedge user_clk);
    chk("rst_desc_rdy", 64'(desc_rdy), 64'd0);
    chk("rst_wr", 64'(rq_tx_wr), 64'd0);
    chk("rst_wdata_zero", 64'(rq_tx_wdata == '0), 64'd1);
    chk("rst_errs", 64'({desc_err, tag_err}), 64'd0);
    chk("rst_busy", 64'(tag_busy_cnt), 64'd0);
    user_rst = 1'b0;
    #1 chk("post_rst_desc_rdy", 64'(desc_rdy), 64'd1);

    // Vector table
    for (int v = 0; v < 8; v++) begin
      reg_req_id = 16'hA000 + 16'(v);
      if (tv[v].exp_derr == 0) model_desc(tv[v].addr, tv[v].len, tv[v].mrrs, reg_req_id);
      d0 = n_derr;
      send_desc(tv[v].addr, tv[v].len, tv[v].mrrs);
      wait_done(1'b0);
      chk("vec_derr", 64'(n_derr - d0), 64'(tv[v].exp_derr));
      chk("vec_ntlp", 64'(got_q.size()), 64'(tv[v].exp_tlps));
      if (got_q.size() > 0) begin
        dd = get_desc(got_q[0]);
        chk("vec_dw0", 64'(dd[74:64]), 64'(tv[v].exp_dw0 == 1024 ? 1024 : tv[v].exp_dw0));
      end
      chk("vec_busy", 64'(tag_busy_cnt), 64'(model_cnt()));
      compare_writes("vec");
      release_all();
    end

    // Backpressure mid-stream
    reg_req_id = 16'h0B0B;
    model_desc(64'h3000, 32'd2048, 3'd0, reg_req_id);
    send_desc(64'h3000, 32'd2048, 3'd0);
    wait_writes(3, 100, "bp_start");
    @(negedge user_clk);
    #1 rq_tx_ff = 1'b1;
    n0 = got_q.size();
    repeat (20) @(negedge user_clk);
    #1 n1 = got_q.size();
    chk("bp_stall_writes", 64'(n1 - n0 <= 1), 64'd1);
    rq_tx_ff = 1'b0;
    wait_done(1'b0);
    compare_writes("bp");
    release_all();

    // Random descriptors with random backpressure
    for (int r = 0; r < 14; r++) begin
      reg_req_id = 16'($urandom);
      ra = {$urandom, $urandom};
      ra[1:0] = 2'b00;
      if (r % 2 == 1) ra[11:0] = 12'hC00 + 12'(4 * $urandom_range(0, 255));
      rl = 32'(4 * $urandom_range(1, 256));
      rm = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) rl = rl + 32'd2;
      if (rl[1:0] == 2'b00) model_desc(ra, rl, rm, reg_req_id);
      d0 = n_derr;
      send_desc(ra, rl, rm);
      wait_done(1'b1);
      chk("rnd_derr", 64'(n_derr - d0), 64'(rl[1:0] != 2'b00));
      chk("rnd_busy", 64'(tag_busy_cnt), 64'(model_cnt()));
      compare_writes("rnd");
      release_all();
    end

    // Tag exhaustion, back-to-back release, bad releases
    reg_req_id = 16'h5A5A;
    send_desc(64'h0, 32'd65536, 3'd0);
    repeat (150) @(negedge user_clk);
    #1 chk("exh_count", 64'(got_q.size()), 64'd32);
    for (int i = 0; i < 32 && i < got_q.size(); i++)
      chk_w("exh_word", got_q[i], exp_word(64'(i * 128), 128, i, reg_req_id));
    chk("exh_busy", 64'(tag_busy_cnt), 64'd32);
    chk("exh_desc_rdy", 64'(desc_rdy), 64'd0);
    got_q.delete();
    t0 = n_terr;
    @(negedge user_clk);
    tag_rls = 1'b1; tag_rls_id = 8'd5;
    @(negedge user_clk);
    @(negedge user_clk);
    tag_rls = 1'b0;
    wait_writes(1, 50, "exh_reuse");
    if (got_q.size() > 0) begin
      dd = get_desc(got_q[0]);
      chk("exh_reuse_tag", 64'(dd[103:96]), 64'd5);
      chk_w("exh_reuse_word", got_q[0], exp_word(64'(32 * 128), 128, 5, reg_req_id));
    end
    chk("exh_double_rls_err", 64'(n_terr - t0), 64'd1);
    release_tag(40);
    @(negedge user_clk);
    chk("exh_oor_rls_err", 64'(n_terr - t0), 64'd2);
    chk("exh_busy2", 64'(tag_busy_cnt), 64'd32);

    // Reset while the descriptor is stalled
    @(negedge user_clk);
    user_rst = 1'b1;
    @(negedge user_clk);
    chk("mid_rst_wr", 64'(rq_tx_wr), 64'd0);
    chk("mid_rst_wdata_zero", 64'(rq_tx_wdata == '0), 64'd1);
    chk("mid_rst_busy", 64'(tag_busy_cnt), 64'd0);
    chk("mid_rst_desc_rdy", 64'(desc_rdy), 64'd0);
    user_rst = 1'b0;
    #1 chk("mid_rst_rdy_after", 64'(desc_rdy), 64'd1);
    for (int t = 0; t < TAG_NUM; t++) mbusy[t] = 1'b0;
    got_q.delete();
    repeat (10) @(negedge user_clk);
    chk("mid_rst_no_writes", 64'(got_q.size()), 64'd0);

    // Reset during a 3-TLP descriptor
    send_desc(64'h5000, 32'd384, 3'd0);
    wait_writes(1, 50, "rst3_first");
    user_rst = 1'b1;
    @(negedge user_clk);
    chk("rst3_wr", 64'(rq_tx_wr), 64'd0);
    chk("rst3_busy", 64'(tag_busy_cnt), 64'd0);
    user_rst = 1'b0;
    got_q.delete();
    #1 chk("rst3_rdy", 64'(desc_rdy), 64'd1);
    repeat (10) @(negedge user_clk);
    chk("rst3_no_writes", 64'(got_q.size()), 64'd0);
    chk("rst3_busy_after", 64'(tag_busy_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
